// File: rtl/ram_ext_pkg.sv
// ram_ext_pkg: access-mode codes, sweep FSM states and the response record
// shared by the ram_ext data RAM and its load formatter.
package ram_ext_pkg;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WORD = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  // Byte-lane enables for a store; reserved mode touches no lane.
  function automatic logic [3:0] byte_en(input logic [1:0] mode, input logic [1:0] a);
    case (mode)
      MODE_BYTE: byte_en = 4'b0001 << a;
      MODE_HALF: byte_en = a[1] ? 4'b1100 : 4'b0011;
      MODE_WORD: byte_en = 4'b1111;
      default:   byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ram_ext_ld_fmt.sv
// ram_ext_ld_fmt: picks the addressed byte/halfword out of a memory word and
// sign- or zero-extends it to 32 bits. Word (and reserved) pass the word through.
module ram_ext_ld_fmt import ram_ext_pkg::*; (
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_mode,
  input  logic        i_sext,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_addr, 3'b000} +: 8];
  assign w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

  // Lane select plus extension by the lane MSB when sext is set.
  always_comb begin
    case (i_mode)
      MODE_BYTE: o_data = {{24{i_sext & w_byte[7]}}, w_byte};
      MODE_HALF: o_data = {{16{i_sext & w_half[15]}}, w_half};
      default:   o_data = i_word;
    endcase
  end

endmodule

// File: rtl/ram_ext.sv
// ram_ext: byte/halfword/word data RAM with valid/ready requests, an RD_LAT
// deep response pipe and a multi-cycle clear sweep after clr.
// Optional macro RAM_EXT_ALIGN_CHK_EN: misaligned halfword/word requests are
// answered with rsp_err and perform no write; otherwise low bits are ignored.
module ram_ext import ram_ext_pkg::*; #(
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_mode,
  input  logic                  req_sext,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_busy
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IW;

  logic [31:0]             r_mem [DEPTH];
  state_t                  r_state, w_state_nxt;
  logic [IW-1:0]           r_ptr;
  logic [RD_LAT-1:0]       r_vld_pipe;
  rsp_t [RD_LAT-1:0]       r_rsp_pipe;

  logic                    w_sweep_we, w_acc, w_misal, w_err, w_wr;
  logic [IW-1:0]           w_idx;
  logic [31:0]             w_rd_word, w_ld, w_wrep;
  logic [3:0]              w_be;
  rsp_t                    w_rsp;

  // Sweep FSM state register; clr always lands in INIT.
  always_ff @(posedge clk) begin
    if (clr) r_state <= ST_INIT;
    else     r_state <= w_state_nxt;
  end

  // Leave INIT once the last word has been cleared.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && r_ptr == '1) w_state_nxt = ST_RUN;
  end

  // FSM outputs; the sweep holds at word 0 while clr stays high.
  always_comb begin
    req_ready  = (r_state == ST_RUN);
    init_busy  = (r_state == ST_INIT);
    w_sweep_we = (r_state == ST_INIT) && !clr;
  end

  // Sweep pointer, restarted by clr.
  always_ff @(posedge clk) begin
    if (clr)             r_ptr <= '0;
    else if (w_sweep_we) r_ptr <= r_ptr + IW'(1);
  end

  assign w_acc     = req_valid && req_ready && !clr;
  assign w_idx     = req_addr[ADDR_WIDTH-1:2];
  assign w_rd_word = r_mem[w_idx];

`ifdef RAM_EXT_ALIGN_CHK_EN
  assign w_misal = (req_mode == MODE_HALF && req_addr[0]) ||
                   (req_mode == MODE_WORD && req_addr[1:0] != 2'b00);
`else
  assign w_misal = 1'b0;
`endif

  assign w_err = (req_mode == MODE_RSVD) || w_misal;
  assign w_wr  = w_acc && req_we && !w_err;
  assign w_be  = byte_en(req_mode, req_addr[1:0]);

  // Replicate the right-aligned store data onto every lane it may target.
  always_comb begin
    case (req_mode)
      MODE_BYTE: w_wrep = {4{req_wdata[7:0]}};
      MODE_HALF: w_wrep = {2{req_wdata[15:0]}};
      default:   w_wrep = req_wdata;
    endcase
  end

  // Memory: sweep clears one word per cycle, stores merge enabled lanes.
  always_ff @(posedge clk) begin
    if (w_sweep_we) r_mem[r_ptr] <= '0;
    else if (w_wr) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wrep[b*8 +: 8];
    end
  end

  ram_ext_ld_fmt u_ld_fmt (
    .i_word (w_rd_word),
    .i_addr (req_addr[1:0]),
    .i_mode (req_mode),
    .i_sext (req_sext),
    .o_data (w_ld)
  );

  // Stores and errors return zero data.
  always_comb begin
    w_rsp      = '0;
    w_rsp.err  = w_err;
    w_rsp.data = (req_we || w_err) ? 32'h0 : w_ld;
  end

  // Response pipe: stage 0 captures at the accept edge; clr flushes in-flight work.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_vld_pipe <= '0;
      r_rsp_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= w_acc;
      r_rsp_pipe[0] <= w_acc ? w_rsp : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_rsp_pipe[i] <= r_rsp_pipe[i-1];
      end
    end
  end

  assign rsp_valid = r_vld_pipe[RD_LAT-1];
  assign rsp_rdata = r_rsp_pipe[RD_LAT-1].data;
  assign rsp_err   = r_rsp_pipe[RD_LAT-1].err;

endmodule

// File: tb/tb_ram_ext.sv
// tb_ram_ext: drives one request stream into three ram_ext copies (RD_LAT 1..3)
// and checks each response stream against a shared expected-response queue.
// Honours RAM_EXT_ALIGN_CHK_EN the same way as the design.
module tb_ram_ext;
  import ram_ext_pkg::*;

  localparam int AW = 6;
  localparam int NI = 3;

  logic                 clk = 1'b0;
  logic                 clr = 1'b1;
  logic                 req_valid = 1'b0;
  logic                 req_we = 1'b0;
  logic                 req_sext = 1'b0;
  logic [1:0]           req_mode = 2'b00;
  logic [AW-1:0]        req_addr = '0;
  logic [31:0]          req_wdata = '0;
  logic [NI-1:0]        req_ready, rsp_valid, rsp_err, init_busy;
  logic [NI-1:0][31:0]  rsp_rdata;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   rd_idx[NI];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ram_ext #(.ADDR_WIDTH(AW), .RD_LAT(g + 1)) u_dut (
      .clk       (clk),
      .clr       (clr),
      .req_valid (req_valid),
      .req_ready (req_ready[g]),
      .req_we    (req_we),
      .req_mode  (req_mode),
      .req_sext  (req_sext),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .init_busy (init_busy[g])
    );
  end

  // One clock: at the falling edge pop and compare any response pulses,
  // then advance past the next rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      if (rsp_valid[g] === 1'b1) begin
        n_cmp++;
        if (rd_idx[g] >= exp_q.size()) begin
          n_fail++;
          $display("FAIL rsp_unexpected lat=%0d cyc=%0d: got a pulse, required none", g + 1, cyc);
        end else begin
          e = exp_q[rd_idx[g]];
          rd_idx[g]++;
          if (rsp_rdata[g] !== e.data || rsp_err[g] !== e.err || cyc != e.cyc + g) begin
            n_fail++;
            $display("FAIL rsp lat=%0d: got data=%h err=%b cyc=%0d, required data=%h err=%b cyc=%0d",
                     g + 1, rsp_rdata[g], rsp_err[g], cyc, e.data, e.err, e.cyc + g);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present one request for one cycle and record the response it must produce.
  task automatic issue(input logic we, input logic [1:0] mode, input logic sext,
                       input logic [AW-1:0] addr, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee);
    exp_t e;
    req_valid = 1'b1; req_we = we; req_mode = mode; req_sext = sext;
    req_addr = addr; req_wdata = wd;
    n_cmp++;
    if (req_ready !== 3'b111) begin
      n_fail++;
      $display("FAIL req_ready addr=%h: got %b, required 111", addr, req_ready);
    end
    step();
    e.data = ed; e.err = ee; e.cyc = cyc;
    exp_q.push_back(e);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) step();
    for (int g = 0; g < NI; g++) begin
      n_cmp++;
      if (rd_idx[g] != exp_q.size()) begin
        n_fail++;
        $display("FAIL rsp_count lat=%0d: got %0d responses, required %0d", g + 1, rd_idx[g], exp_q.size());
      end
    end
  endtask

  // Sweep after the clr edge: busy through edge r+15, ready after edge r+16.
  task automatic wait_sweep(input string tag);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 15) begin
        n_cmp++;
        if (init_busy !== 3'b111 || req_ready !== 3'b000) begin
          n_fail++;
          $display("FAIL %s_busy15: got busy=%b ready=%b, required 111/000", tag, init_busy, req_ready);
        end
      end
      if (k == 16) begin
        n_cmp++;
        if (init_busy !== 3'b000 || req_ready !== 3'b111) begin
          n_fail++;
          $display("FAIL %s_ready16: got busy=%b ready=%b, required 000/111", tag, init_busy, req_ready);
        end
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    step(); step();
    n_cmp++;
    if (rsp_valid !== 3'b000 || rsp_err !== 3'b000 || rsp_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: got v=%b e=%b d=%h, required zeros", rsp_valid, rsp_err, rsp_rdata);
    end
    n_cmp++;
    if (req_ready !== 3'b000 || init_busy !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_ctl: got ready=%b busy=%b, required 000/111", req_ready, init_busy);
    end
    step();
    n_cmp++;
    if (init_busy !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_hold: got busy=%b, required 111", init_busy);
    end
    clr = 1'b0;
    wait_sweep("sweep");
    issue(1'b0, MODE_WORD, 1'b0, 6'h3C, 32'h0, 32'h0000_0000, 1'b0);
    drain();
  endtask

  task automatic test_byte();
    issue(1'b1, MODE_WORD, 1'b0, 6'h10, 32'h1234_5678, 32'h0, 1'b0);
    issue(1'b1, MODE_BYTE, 1'b0, 6'h11, 32'h0000_00AB, 32'h0, 1'b0);
    issue(1'b0, MODE_WORD, 1'b0, 6'h10, 32'h0, 32'h1234_AB78, 1'b0);
    issue(1'b0, MODE_BYTE, 1'b1, 6'h11, 32'h0, 32'hFFFF_FFAB, 1'b0);
    issue(1'b0, MODE_BYTE, 1'b0, 6'h11, 32'h0, 32'h0000_00AB, 1'b0);
    issue(1'b0, MODE_HALF, 1'b1, 6'h12, 32'h0, 32'h0000_1234, 1'b0);
    issue(1'b0, MODE_BYTE, 1'b1, 6'h13, 32'h0, 32'h0000_0012, 1'b0);
    issue(1'b0, MODE_HALF, 1'b1, 6'h10, 32'h0, 32'hFFFF_AB78, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    issue(1'b1, MODE_HALF, 1'b0, 6'h22, 32'h5555_8001, 32'h0, 1'b0);
    issue(1'b0, MODE_HALF, 1'b1, 6'h22, 32'h0, 32'hFFFF_8001, 1'b0);
    issue(1'b0, MODE_HALF, 1'b0, 6'h20, 32'h0, 32'h0000_0000, 1'b0);
    issue(1'b1, MODE_WORD, 1'b0, 6'h24, 32'hCAFE_F00D, 32'h0, 1'b0);
    issue(1'b0, MODE_WORD, 1'b1, 6'h24, 32'h0, 32'hCAFE_F00D, 1'b0);
    issue(1'b0, MODE_BYTE, 1'b1, 6'h27, 32'h0, 32'hFFFF_FFCA, 1'b0);
    issue(1'b0, MODE_HALF, 1'b0, 6'h24, 32'h0, 32'h0000_F00D, 1'b0);
    issue(1'b0, MODE_BYTE, 1'b0, 6'h25, 32'h0, 32'h0000_00F0, 1'b0);
    drain();
  endtask

  task automatic test_reserved();
    issue(1'b1, MODE_RSVD, 1'b0, 6'h20, 32'hFFFF_FFFF, 32'h0, 1'b1);
    issue(1'b0, MODE_WORD, 1'b0, 6'h20, 32'h0, 32'h8001_0000, 1'b0);
    issue(1'b0, MODE_RSVD, 1'b1, 6'h20, 32'h0, 32'h0, 1'b1);
    drain();
  endtask

  task automatic test_misalign();
`ifdef RAM_EXT_ALIGN_CHK_EN
    issue(1'b1, MODE_WORD, 1'b0, 6'h13, 32'hDEAD_BEEF, 32'h0, 1'b1);
    issue(1'b0, MODE_WORD, 1'b0, 6'h10, 32'h0, 32'h1234_AB78, 1'b0);
    issue(1'b0, MODE_HALF, 1'b0, 6'h23, 32'h0, 32'h0, 1'b1);
    issue(1'b1, MODE_HALF, 1'b0, 6'h21, 32'h0000_7777, 32'h0, 1'b1);
    issue(1'b0, MODE_WORD, 1'b0, 6'h20, 32'h0, 32'h8001_0000, 1'b0);
`else
    issue(1'b1, MODE_WORD, 1'b0, 6'h13, 32'hDEAD_BEEF, 32'h0, 1'b0);
    issue(1'b0, MODE_WORD, 1'b0, 6'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, MODE_HALF, 1'b0, 6'h23, 32'h0, 32'h0000_8001, 1'b0);
    issue(1'b1, MODE_HALF, 1'b0, 6'h21, 32'h0000_7777, 32'h0, 1'b0);
    issue(1'b0, MODE_WORD, 1'b0, 6'h20, 32'h0, 32'h8001_7777, 1'b0);
`endif
    drain();
  endtask

  task automatic test_clr_midstream();
    logic [31:0] w20;
`ifdef RAM_EXT_ALIGN_CHK_EN
    w20 = 32'h8001_0000;
`else
    w20 = 32'h8001_7777;
`endif
    issue(1'b0, MODE_WORD, 1'b0, 6'h24, 32'h0, 32'hCAFE_F00D, 1'b0);
    issue(1'b0, MODE_WORD, 1'b0, 6'h20, 32'h0, w20, 1'b0);
    issue(1'b0, MODE_BYTE, 1'b0, 6'h27, 32'h0, 32'h0000_00CA, 1'b0);
    clr = 1'b1;
    step();
    // Whatever was still in flight at the clr edge is gone for every copy.
    for (int g = 0; g < NI; g++) rd_idx[g] = exp_q.size();
    clr = 1'b0;
    n_cmp++;
    if (rsp_valid !== 3'b000 || init_busy !== 3'b111 || req_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL clr_flush: got v=%b busy=%b ready=%b, required 000/111/000", rsp_valid, init_busy, req_ready);
    end
    wait_sweep("resweep");
    issue(1'b0, MODE_WORD, 1'b0, 6'h24, 32'h0, 32'h0000_0000, 1'b0);
    issue(1'b0, MODE_WORD, 1'b0, 6'h10, 32'h0, 32'h0000_0000, 1'b0);
    drain();
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_byte();
    test_back_to_back();
    test_reserved();
    test_misalign();
    test_clr_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
